// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, write-to-read bypass
// and a one-cycle registered read on two independent ports.
module regfile_sb #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 32,
   parameter int ZERO_R0    = 1,
   parameter int INIT_INDEX = 1,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [AW-1:0]    selwr,
   input  logic [WIDTH-1:0] in,
   input  logic             rd,
   input  logic [AW-1:0]    selrd1,
   input  logic [AW-1:0]    selrd2,
   input  logic             rsv,
   input  logic [AW-1:0]    selrsv,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic             busy1,
   output logic             busy2,
   output logic             anybusy
);

   localparam int          NPORT   = 2;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   // An index is usable when it addresses a real register that is not hardwired.
   function automatic logic idx_ok(input logic [AW-1:0] idx);
      return ({1'b0, idx} < DEPTH_W) && !((ZERO_R0 != 0) && (idx == '0));
   endfunction

   logic [WIDTH-1:0]             r_mem [DEPTH];
   logic [DEPTH-1:0]             r_busy;
   logic [DEPTH-1:0]             w_busy_nxt;
   logic                         w_wr_ok;
   logic                         w_rsv_ok;
   logic [NPORT-1:0][AW-1:0]     w_sel;
   logic [NPORT-1:0]             w_hit;
   logic [NPORT-1:0][WIDTH-1:0]  w_rdata;
   logic [NPORT-1:0]             w_rbusy;
   logic [NPORT-1:0][WIDTH-1:0]  r_out;
   logic [NPORT-1:0]             r_bsy;

   assign w_wr_ok  = wr  && idx_ok(selwr);
   assign w_rsv_ok = rsv && idx_ok(selrsv);

   // Set is applied after clear so a same-cycle reserve of the written index wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_ok)  w_busy_nxt[selwr]  = 1'b0;
      if (w_rsv_ok) w_busy_nxt[selrsv] = 1'b1;
   end

   assign w_sel = {selrd2, selrd1};

   for (genvar gp = 0; gp < NPORT; gp++) begin : g_port
      assign w_hit[gp]   = idx_ok(w_sel[gp]);
      assign w_rdata[gp] = !w_hit[gp]                         ? '0 :
                           (w_wr_ok && (selwr == w_sel[gp])) ? in :
                                                                r_mem[w_sel[gp]];
      assign w_rbusy[gp] = w_hit[gp] & w_busy_nxt[w_sel[gp]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= ((INIT_INDEX != 0) && !((ZERO_R0 != 0) && (i == 0))) ? WIDTH'(i) : '0;
         r_busy <= '0;
      end else begin
         if (w_wr_ok) r_mem[selwr] <= in;
         r_busy <= w_busy_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
         r_bsy <= '0;
      end else if (rd) begin
         r_out <= w_rdata;
         r_bsy <= w_rbusy;
      end
   end

   assign out1    = r_out[0];
   assign out2    = r_out[1];
   assign busy1   = r_bsy[0];
   assign busy2   = r_bsy[1];
   assign anybusy = |r_busy;

endmodule
